// File: rtl/mc_controller.sv
// Multi-cycle MIPS control FSM: sequences fetch, decode, memory, ALU and write-back
// steps and drives the datapath selects and qualified register/PC/memory enables.
module mc_controller #(
    parameter logic [5:0] OP_RTYPE = 6'h00,
    parameter logic [5:0] OP_LW    = 6'h23,
    parameter logic [5:0] OP_SW    = 6'h2B,
    parameter logic [5:0] OP_BEQ   = 6'h04,
    parameter logic [5:0] OP_ADDI  = 6'h08,
    parameter logic [5:0] OP_J     = 6'h02
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSrc,
    output logic       PCWrite,
    output logic       illegal_op,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        BRANCH = 4'd8,
        ADDIEX = 4'd9,
        ADDIWB = 4'd10,
        JUMP   = 4'd11
    } state_t;

    state_t curState, nextState;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            curState <= FETCH;
        else
            curState <= nextState;
    end

    assign state = curState;

    always_comb begin
        nextState  = FETCH;
        IorD       = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        RegDst     = 1'b0;
        MemtoReg   = 1'b0;
        RegWrite   = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'd0;
        ALUOp      = 2'd0;
        PCSrc      = 2'd0;
        PCWrite    = 1'b0;
        illegal_op = 1'b0;

        case (curState)
            FETCH: begin
                MemRead   = 1'b1;
                ALUSrcB   = 2'd1;
                IRWrite   = mem_ready;
                PCWrite   = mem_ready;
                nextState = mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                // ALU precomputes the branch target while the opcode is examined
                ALUSrcB = 2'd3;
                case (op)
                    OP_LW, OP_SW: nextState = MEMADR;
                    OP_RTYPE:     nextState = EXEC;
                    OP_BEQ:       nextState = BRANCH;
                    OP_ADDI:      nextState = ADDIEX;
                    OP_J:         nextState = JUMP;
                    default: begin
                        nextState  = FETCH;
                        illegal_op = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'd2;
                nextState = (op == OP_SW) ? MEMWR : MEMRD;
            end
            MEMRD: begin
                MemRead   = 1'b1;
                IorD      = 1'b1;
                nextState = mem_ready ? MEMWB : MEMRD;
            end
            MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            MEMWR: begin
                MemWrite  = 1'b1;
                IorD      = 1'b1;
                nextState = mem_ready ? FETCH : MEMWR;
            end
            EXEC: begin
                ALUSrcA   = 1'b1;
                ALUOp     = 2'd2;
                nextState = ALUWB;
            end
            ALUWB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
            end
            BRANCH: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'd1;
                PCSrc   = 2'd1;
                PCWrite = zero;
            end
            ADDIEX: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'd2;
                nextState = ADDIWB;
            end
            ADDIWB: begin
                RegWrite = 1'b1;
            end
            JUMP: begin
                PCSrc   = 2'd2;
                PCWrite = 1'b1;
            end
            default: nextState = FETCH;
        endcase

        // Reset holds FETCH, so its request/load strobes must be suppressed explicitly
        if (reset) begin
            MemRead    = 1'b0;
            MemWrite   = 1'b0;
            IRWrite    = 1'b0;
            RegWrite   = 1'b0;
            PCWrite    = 1'b0;
            illegal_op = 1'b0;
        end
    end

endmodule

// File: tb/tb_mc_controller.sv
// Testbench for mc_controller: directed and randomized instruction sequences compared
// against a per-instruction state-trace model and a per-state control table.
module tb_mc_controller;

    logic       clk;
    logic       reset;
    logic [5:0] op;
    logic       zero;
    logic       mem_ready;
    logic       IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB, ALUOp, PCSrc;
    logic       PCWrite, illegal_op;
    logic [3:0] state;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic       iord, memRead, memWrite, irWrite, regDst, memToReg, regWrite, aluSrcA;
        logic [1:0] aluSrcB, aluOp, pcSrc;
        logic       pcWrite, illegal;
    } ctl_t;

    typedef struct {
        int   st;
        logic mr;
    } step_t;

    ctl_t  ctlTable [12];
    step_t trace [$];

    mc_controller dut (
        .clk(clk), .reset(reset), .op(op), .zero(zero), .mem_ready(mem_ready),
        .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSrc(PCSrc), .PCWrite(PCWrite),
        .illegal_op(illegal_op), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic isLegal(input logic [5:0] o);
        return (o == 6'h00) || (o == 6'h23) || (o == 6'h2B) ||
               (o == 6'h04) || (o == 6'h08) || (o == 6'h02);
    endfunction

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic mr, input logic z);
        mem_ready = mr;
        zero      = z;
        #1;
    endtask

    task automatic checkOutput(input int st, input logic mr, input logic z);
        ctl_t exp;
        ctl_t obs;
        exp = ctlTable[st];
        if (st == 0) begin
            exp.irWrite = mr;
            exp.pcWrite = mr;
        end
        if (st == 8) exp.pcWrite = z;
        if (st == 1) exp.illegal = !isLegal(op);
        obs = {IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
               ALUSrcB, ALUOp, PCSrc, PCWrite, illegal_op};
        checkVal("state", 32'(state), 32'(st));
        checkVal($sformatf("ctl_s%0d_op%0h", st, op), 32'(obs), 32'(exp));
    endtask

    // Builds the expected state walk of one instruction, then steps the DUT through it
    task automatic runInstr(input logic [5:0] o, input logic zeroVal,
                            input int fetchWaits, input int memWaits);
        int   regWrites = 0;
        int   memWrites = 0;
        int   pcWrites  = 0;
        logic z;
        op = o;
        trace.delete();
        for (int i = 0; i < fetchWaits; i++) trace.push_back('{0, 1'b0});
        trace.push_back('{0, 1'b1});
        trace.push_back('{1, 1'($urandom)});
        if (isLegal(o)) begin
            case (o)
                6'h23: begin
                    trace.push_back('{2, 1'($urandom)});
                    for (int i = 0; i < memWaits; i++) trace.push_back('{3, 1'b0});
                    trace.push_back('{3, 1'b1});
                    trace.push_back('{4, 1'($urandom)});
                end
                6'h2B: begin
                    trace.push_back('{2, 1'($urandom)});
                    for (int i = 0; i < memWaits; i++) trace.push_back('{5, 1'b0});
                    trace.push_back('{5, 1'b1});
                end
                6'h00: begin
                    trace.push_back('{6, 1'($urandom)});
                    trace.push_back('{7, 1'($urandom)});
                end
                6'h08: begin
                    trace.push_back('{9, 1'($urandom)});
                    trace.push_back('{10, 1'($urandom)});
                end
                6'h04:   trace.push_back('{8, 1'($urandom)});
                default: trace.push_back('{11, 1'($urandom)});
            endcase
        end
        foreach (trace[i]) begin
            z = (trace[i].st == 8) ? zeroVal : 1'($urandom);
            applyStimulus(trace[i].mr, z);
            checkOutput(trace[i].st, trace[i].mr, z);
            regWrites += int'(RegWrite);
            memWrites += int'(MemWrite);
            pcWrites  += int'(PCWrite);
            @(posedge clk);
            #1;
        end
        checkVal($sformatf("regwrite_count_op%0h", o), 32'(regWrites),
                 (o == 6'h23 || o == 6'h00 || o == 6'h08) ? 32'd1 : 32'd0);
        checkVal($sformatf("memwrite_cycles_op%0h", o), 32'(memWrites),
                 (o == 6'h2B) ? 32'(memWaits + 1) : 32'd0);
        checkVal($sformatf("pcwrite_count_op%0h", o), 32'(pcWrites),
                 32'(1 + ((o == 6'h02) ? 1 : 0) + ((o == 6'h04 && zeroVal) ? 1 : 0)));
        checkVal("end_state", 32'(state), 32'd0);
    endtask

    initial begin
        logic [5:0] legalOps [6];
        logic [5:0] o;
        legalOps = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h02};
        ctlTable = '{
            ctl_t'(16'b0_1_0_0_0_0_0_0_01_00_00_0_0),
            ctl_t'(16'b0_0_0_0_0_0_0_0_11_00_00_0_0),
            ctl_t'(16'b0_0_0_0_0_0_0_1_10_00_00_0_0),
            ctl_t'(16'b1_1_0_0_0_0_0_0_00_00_00_0_0),
            ctl_t'(16'b0_0_0_0_0_1_1_0_00_00_00_0_0),
            ctl_t'(16'b1_0_1_0_0_0_0_0_00_00_00_0_0),
            ctl_t'(16'b0_0_0_0_0_0_0_1_00_10_00_0_0),
            ctl_t'(16'b0_0_0_0_1_0_1_0_00_00_00_0_0),
            ctl_t'(16'b0_0_0_0_0_0_0_1_00_01_01_0_0),
            ctl_t'(16'b0_0_0_0_0_0_0_1_10_00_00_0_0),
            ctl_t'(16'b0_0_0_0_0_0_1_0_00_00_00_0_0),
            ctl_t'(16'b0_0_0_0_0_0_0_0_00_00_10_1_0)
        };

        // Reset held with mem_ready high: FETCH strobes must stay quiet
        reset = 1'b1;
        mem_ready = 1'b1;
        zero = 1'b0;
        op = 6'h00;
        repeat (3) begin
            @(posedge clk);
            #1;
            checkVal("reset_state", 32'(state), 32'd0);
            checkVal("reset_enables",
                     32'({MemRead, MemWrite, IRWrite, RegWrite, PCWrite, illegal_op}), 32'd0);
        end
        reset = 1'b0;

        runInstr(6'h23, 1'b0, 0, 0);
        runInstr(6'h2B, 1'b0, 0, 3);
        runInstr(6'h04, 1'b1, 0, 0);
        runInstr(6'h04, 1'b0, 0, 0);
        runInstr(6'h00, 1'b0, 0, 0);
        runInstr(6'h08, 1'b0, 0, 0);
        runInstr(6'h3F, 1'b0, 0, 0);
        runInstr(6'h02, 1'b0, 2, 0);

        // Abort a load while waiting in MEMRD
        op = 6'h23;
        applyStimulus(1'b1, 1'b0);
        checkOutput(0, 1'b1, 1'b0);
        @(posedge clk); #1;
        applyStimulus(1'b1, 1'b0);
        checkOutput(1, 1'b1, 1'b0);
        @(posedge clk); #1;
        applyStimulus(1'b1, 1'b0);
        checkOutput(2, 1'b1, 1'b0);
        @(posedge clk); #1;
        applyStimulus(1'b0, 1'b0);
        checkOutput(3, 1'b0, 1'b0);
        reset = 1'b1;
        mem_ready = 1'b1;
        #1;
        checkVal("abort_state", 32'(state), 32'd0);
        checkVal("abort_enables",
                 32'({MemRead, MemWrite, IRWrite, RegWrite, PCWrite, illegal_op}), 32'd0);
        @(posedge clk); #1;
        checkVal("abort_hold_state", 32'(state), 32'd0);
        checkVal("abort_hold_regwrite", 32'(RegWrite), 32'd0);
        reset = 1'b0;

        for (int n = 0; n < 50; n++) begin
            if ($urandom_range(0, 6) == 6) begin
                o = 6'($urandom_range(0, 63));
                if (isLegal(o)) o = 6'h3F;
            end else begin
                o = legalOps[$urandom_range(0, 5)];
            end
            runInstr(o, 1'($urandom), int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
